// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : memory_pkg
//  Purpose  : Shared encodings for the memory request interface.
//  Revision : 1.0  initial release
// ============================================================================
package memory_pkg;

    localparam logic c_MEM_WR = 1'b1;
    localparam logic c_MEM_RD = 1'b0;

endpackage
`default_nettype wire

// File: rtl/memory.sv
`default_nettype none
// ============================================================================
//  Module   : memory
//  Purpose  : Single-port register-array RAM behind a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module memory
    import memory_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int DEPTH      = 32,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    input  logic                  valid,
    output logic                  ready
);

    // Flop array rather than a RAM macro so the whole store can clear asynchronously.
    logic [DEPTH-1:0][WIDTH-1:0] r_mem_q;
    logic [DEPTH-1:0][WIDTH-1:0] w_mem_d;
    logic [WIDTH-1:0]            r_rdata_q;
    logic [WIDTH-1:0]            w_rdata_d;
    logic                        r_ready_q;
    logic                        w_ready_d;

    logic w_wr_req;
    logic w_rd_req;

    assign w_wr_req = valid && (wr_rd == c_MEM_WR);
    assign w_rd_req = valid && (wr_rd == c_MEM_RD);

    always_comb begin
        w_mem_d   = r_mem_q;
        w_rdata_d = r_rdata_q;
        w_ready_d = valid;
        if (w_wr_req) begin
            w_mem_d[addr] = wdata;
        end
        if (w_rd_req) begin
            w_rdata_d = r_mem_q[addr];
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_mem_q   <= '0;
            r_rdata_q <= '0;
            r_ready_q <= 1'b0;
        end else begin
            r_mem_q   <= w_mem_d;
            r_rdata_q <= w_rdata_d;
            r_ready_q <= w_ready_d;
        end
    end

    assign rdata = r_rdata_q;
    assign ready = r_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory
//  Purpose  : Self-checking bench for memory against an array-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_memory;
    import memory_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic             clk;
    logic             res;
    logic             wr_rd;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             valid;
    logic             ready;

    int checks   = 0;
    int failures = 0;

    memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .res   (res),
        .wr_rd (wr_rd),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .valid (valid),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an array plus the two observable output values.
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic [WIDTH-1:0] m_rdata;
    logic             m_ready;

    always @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_rdata = '0;
            m_ready = 1'b0;
        end else if (valid) begin
            if (wr_rd == c_MEM_WR) m_mem[addr] = wdata;
            else                   m_rdata = m_mem[addr];
            m_ready = 1'b1;
        end else begin
            m_ready = 1'b0;
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!res) begin
            check("model_ready", {7'd0, ready}, {7'd0, m_ready});
            check("model_rdata", rdata, m_rdata);
        end
    end

    // Drives one request for one edge and returns 2ns after that edge.
    task automatic issue(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [WIDTH-1:0] d);
        valid = v;
        wr_rd = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #2;
    endtask

    logic [WIDTH-1:0] written [DEPTH];

    initial begin
        res = 1'b1; valid = 1'b0; wr_rd = c_MEM_RD; addr = '0; wdata = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("reset_ready", {7'd0, ready}, 8'h00);
        check("reset_rdata", rdata, 8'h00);
        res = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, c_MEM_RD, AW'(i), 8'h00);
            check("init_read", rdata, 8'h00);
            check("init_ready", {7'd0, ready}, 8'h01);
        end

        for (int i = 0; i < DEPTH; i++) begin
            written[i] = 8'($urandom_range(0, 255));
            issue(1'b1, c_MEM_WR, AW'(i), written[i]);
            check("fill_ready", {7'd0, ready}, 8'h01);
        end
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, c_MEM_RD, AW'(i), 8'h00);
            check("readback", rdata, written[i]);
        end

        // Single-cycle handshake and idle hold.
        issue(1'b1, c_MEM_WR, 5'd5, 8'hA5);
        check("wr5_ready", {7'd0, ready}, 8'h01);
        issue(1'b0, c_MEM_WR, 5'd5, 8'hA5);
        check("idle_ready", {7'd0, ready}, 8'h00);
        issue(1'b1, c_MEM_RD, 5'd5, 8'h00);
        check("rd5", rdata, 8'hA5);
        repeat (3) issue(1'b0, c_MEM_RD, 5'd9, 8'h77);
        check("idle_hold", rdata, 8'hA5);
        check("idle_ready2", {7'd0, ready}, 8'h00);

        // Back-to-back read-after-write and boundary addresses.
        issue(1'b1, c_MEM_WR, 5'd3, 8'h11);
        issue(1'b1, c_MEM_RD, 5'd3, 8'h00);
        check("raw_11", rdata, 8'h11);
        issue(1'b1, c_MEM_WR, 5'd3, 8'h22);
        issue(1'b1, c_MEM_RD, 5'd3, 8'h00);
        check("raw_22", rdata, 8'h22);
        issue(1'b1, c_MEM_WR, 5'd0, 8'hFF);
        issue(1'b1, c_MEM_WR, 5'd31, 8'h00);
        issue(1'b1, c_MEM_RD, 5'd0, 8'h00);
        check("addr0", rdata, 8'hFF);
        issue(1'b1, c_MEM_RD, 5'd31, 8'h00);
        check("addr31", rdata, 8'h00);

        // A read with wdata driven must leave the word untouched.
        issue(1'b1, c_MEM_WR, 5'd10, 8'h3C);
        repeat (3) issue(1'b1, c_MEM_RD, 5'd10, 8'hEE);
        issue(1'b0, c_MEM_RD, 5'd10, 8'hEE);
        issue(1'b1, c_MEM_RD, 5'd10, 8'h00);
        check("rd_no_disturb", rdata, 8'h3C);

        // Randomized traffic, checked every cycle by the model compare.
        for (int n = 0; n < 400; n++) begin
            issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(0, 255)));
        end

        // Asynchronous reset between edges while a write is in flight.
        issue(1'b1, c_MEM_RD, 5'd0, 8'h00);
        issue(1'b1, c_MEM_WR, 5'd7, 8'h5C);
        check("pre_rst_ready", {7'd0, ready}, 8'h01);
        #1 res = 1'b1;
        #1;
        check("async_ready", {7'd0, ready}, 8'h00);
        check("async_rdata", rdata, 8'h00);
        valid = 1'b0;
        @(posedge clk);
        #2 res = 1'b0;
        issue(1'b1, c_MEM_RD, 5'd7, 8'h00);
        check("post_rst_rd7", rdata, 8'h00);
        check("post_rst_ready", {7'd0, ready}, 8'h01);
        issue(1'b0, c_MEM_RD, 5'd0, 8'h00);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory.md
Name: memory

Overview:
- Single-port synchronous RAM, WIDTH x DEPTH, behind a valid/ready request handshake.
- One request per cycle: write (wr_rd=1) or read (wr_rd=0) at addr.
- Used as a generic scratch/storage block for a bus master that holds each request until ready is seen.
- All activity on one clock; asynchronous active-high reset clears contents and outputs.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 32, number of words.
- ADDR_WIDTH, $clog2(DEPTH) = 5, address width. Derived; not overridden independently.

Ports:
- clk  input  1  rising-edge clock.
- res  input  1  asynchronous reset, active-high.
- wr_rd  input  1  request type: 1 = write, 0 = read; qualified by valid.
- addr  input  ADDR_WIDTH  word address.
- wdata  input  WIDTH  write data; used only when wr_rd=1.
- rdata  output  WIDTH  read data; registered.
- valid  input  1  request valid.
- ready  output  1  request completed this cycle; registered.
- Positional order at instantiation: clk, res, wr_rd, addr, wdata, rdata, valid, ready.

Behaviour:
- Reset (res=1, asynchronous, immediate):
  - all DEPTH words cleared to 0;
  - rdata=0, ready=0;
  - held while res=1.
- Reset mid-operation: any in-flight request is dropped, memory is cleared, and ready=0 the same instant. The master must re-issue after res deasserts.
- Write:
  - At a rising edge with res=0, valid=1, wr_rd=1: mem[addr] <= wdata, ready <= 1.
  - rdata holds its previous value.
- Read:
  - At a rising edge with res=0, valid=1, wr_rd=0: rdata <= mem[addr], ready <= 1.
  - Memory unchanged.
- Idle: at a rising edge with valid=0, ready <= 0, rdata holds, memory unchanged.
- Latency: one cycle. Request sampled at edge N gives ready=1 (and rdata for reads) after edge N, valid until edge N+1.
- Handshake:
  - No back-pressure; every valid request completes at the first edge it is sampled.
  - The master holds addr/wdata/wr_rd/valid until it sees ready.
  - If valid stays high, a new access is performed every cycle and ready stays 1.
  - Repeating an identical write is harmless.
- Read of a location never written since reset returns 0.
- Read-after-write to the same address in back-to-back cycles returns the newly written data. There are no simultaneous read and write on the single port.
- Address range: DEPTH must be a power of two, so every addr value is in range and no wrap handling is needed.
- Memory is a register array, not an inferred RAM macro, so that asynchronous clear is possible.

Decomposition:
- No shared package required. WIDTH/DEPTH/ADDR_WIDTH are local parameters of the block.
- The optional shared constant for a bench is MEM_WR=1'b1 / MEM_RD=1'b0 for wr_rd encoding.
- Single module; no sub-module is natural.

Test Plan:
- Reset: hold res=1 for 2 cycles -> rdata=0, ready=0. Then read addr 0..31 -> each rdata=0x00 with ready=1.
- Fill/readback: write addr i = pseudo-random byte for i=0..31, one request per handshake. Then read addr 0..31 -> rdata equals the written byte each time; ready=1 one cycle after each valid.
- Latency/idle:
  - valid=1, wr_rd=1, addr=5, wdata=0xA5 for one edge, then valid=0 -> ready=1 for exactly one cycle, then 0.
  - Read addr 5 -> rdata=0xA5 one cycle after the request.
  - rdata unchanged while idle.
- Back-to-back: write addr 3=0x11, next cycle read addr 3 -> rdata=0x11. Then write addr 3=0x22 and read -> 0x22. Boundary addresses 0 and 31 with 0xFF/0x00.
- Reset mid-operation: write addr 7=0x5C, then assert res asynchronously between edges -> ready and rdata drop to 0 immediately. After release, read addr 7 -> 0x00.
- Read does not disturb: read addr 10 repeatedly with wdata=0xEE driven -> mem[10] unchanged, verified by later read.
